instr_boot_loader: RTL and testbench

INSTR_BOOT_LOADER -- requirements
Module: instr_boot_loader

---
 rtl/instr_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_boot_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_boot_loader.sv
// Serial boot loader: receives a framed program over a byte stream,
// writes it into instruction memory and releases the core on a good checksum.
module instr_boot_loader #(
  parameter int         MAX_WORDS      = 256,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_rst_n,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int IW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LP_TO_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   LP_MAX     = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [15:0]   r_len;
  logic [1:0]    r_byte_cnt;
  logic [15:0]   r_word_idx;
  logic [31:0]   r_word;
  logic [7:0]    r_cksum;
  logic [IW-1:0] r_idle_cnt;
  logic          r_wr_en;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_core_rst_n;
  logic          r_boot_done;
  logic          r_boot_err;

  logic [15:0]   w_len;
  logic          w_len_bad;
  logic [31:0]   w_word;
  logic          w_last_word;
  logic          w_is_sync;
  logic          w_in_frame;
  logic          w_timeout;

  assign w_len       = {rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > LP_MAX);
  assign w_word      = {rx_data, r_word[31:8]};
  assign w_last_word = (r_word_idx == (r_len - 16'd1));
  assign w_is_sync   = (rx_data == SYNC_BYTE);

  assign w_in_frame = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CKSUM);

  // An arriving byte always beats the timeout on the same cycle.
  assign w_timeout = !rx_valid && (r_idle_cnt == LP_TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_byte_cnt   <= '0;
      r_word_idx   <= '0;
      r_word       <= '0;
      r_cksum      <= '0;
      r_idle_cnt   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_core_rst_n <= 1'b0;
      r_boot_done  <= 1'b0;
      r_boot_err   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;

      if (w_in_frame && !rx_valid)
        r_idle_cnt <= r_idle_cnt + IW'(1);
      else
        r_idle_cnt <= '0;

      if (w_in_frame && w_timeout) begin
        r_state    <= S_ERROR;
        r_boot_err <= 1'b1;
      end else if (rx_valid) begin
        unique case (r_state)
          S_IDLE, S_ERROR: begin
            if (w_is_sync) begin
              r_state    <= S_LEN0;
              r_len      <= '0;
              r_byte_cnt <= '0;
              r_word_idx <= '0;
              r_word     <= '0;
              r_cksum    <= '0;
              r_boot_err <= 1'b0;
            end
          end
          S_LEN0: begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN1;
          end
          S_LEN1: begin
            r_len[15:8] <= rx_data;
            if (w_len_bad) begin
              r_state    <= S_ERROR;
              r_boot_err <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_cksum    <= r_cksum ^ rx_data;
            r_word     <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= {14'd0, r_word_idx, 2'b00};
              r_wr_data  <= w_word;
              r_word_idx <= r_word_idx + 16'd1;
              if (w_last_word)
                r_state <= S_CKSUM;
            end
          end
          S_CKSUM: begin
            if (rx_data == r_cksum) begin
              r_state      <= S_DONE;
              r_core_rst_n <= 1'b1;
              r_boot_done  <= 1'b1;
            end else begin
              r_state    <= S_ERROR;
              r_boot_err <= 1'b1;
            end
          end
          S_DONE: begin
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign core_rst_n   = r_core_rst_n;
  assign boot_done    = r_boot_done;
  assign boot_err     = r_boot_err;

endmodule

// File: tb/tb_instr_boot_loader.sv
// Directed bench for instr_boot_loader: frames, bad checksum, bad length,
// idle timeout, mid-frame reset and stray bytes.
module tb_instr_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        core_rst_n;
  logic        boot_done;
  logic        boot_err;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int base;
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  instr_boot_loader #(
    .MAX_WORDS(4),
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_rst_n(core_rst_n),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with the strobe high is logged, so a stretched strobe
  // shows up as an extra write.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      if (wr_cnt < 64) begin
        wa[wr_cnt] <= imem_wr_addr;
        wd[wr_cnt] <= imem_wr_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Two words: 0x20080013, 0x1008FFFF; good checksum is 0x23.
  task automatic frame_a(input logic [7:0] ck);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h08); send(8'h20);
    send(8'hFF); send(8'hFF); send(8'h08); send(8'h10);
    send(ck);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_en", imem_wr_en, 0);
    chk("rst_addr", imem_wr_addr, 0);
    chk("rst_data", imem_wr_data, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_done", boot_done, 0);
    chk("rst_err", boot_err, 0);
    rst_n = 1'b1;

    // stray bytes before sync
    base = wr_cnt;
    send(8'h00); send(8'h13); send(8'h5A); send(8'h02);
    idle(2);
    chk("pre_sync_wr", wr_cnt - base, 0);
    chk("pre_sync_done", boot_done, 0);
    chk("pre_sync_err", boot_err, 0);

    // good frame
    base = wr_cnt;
    frame_a(8'h23);
    idle(1);
    chk("a_done", boot_done, 1);
    chk("a_core", core_rst_n, 1);
    chk("a_err", boot_err, 0);
    chk("a_nwr", wr_cnt - base, 2);
    chk("a_addr0", wa[base], 32'h0);
    chk("a_data0", wd[base], 32'h20080013);
    chk("a_addr1", wa[base+1], 32'h4);
    chk("a_data1", wd[base+1], 32'h1008FFFF);

    // bytes after DONE
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h00);
    idle(2);
    chk("post_done_wr", wr_cnt - base, 0);
    chk("post_done_done", boot_done, 1);
    chk("post_done_core", core_rst_n, 1);

    // bad checksum, then recovery with a new frame
    pulse_reset();
    chk("rst2_done", boot_done, 0);
    chk("rst2_core", core_rst_n, 0);
    base = wr_cnt;
    frame_a(8'hDC);
    idle(1);
    chk("bad_ck_err", boot_err, 1);
    chk("bad_ck_core", core_rst_n, 0);
    chk("bad_ck_done", boot_done, 0);
    chk("bad_ck_nwr", wr_cnt - base, 2);
    base = wr_cnt;
    send(8'hA5); send(8'h02);
    chk("err_clr", boot_err, 0);
    send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h88); send(8'h77); send(8'h66); send(8'h55);
    send(8'h88);
    idle(1);
    chk("b_done", boot_done, 1);
    chk("b_err", boot_err, 0);
    chk("b_core", core_rst_n, 1);
    chk("b_nwr", wr_cnt - base, 2);
    chk("b_addr0", wa[base], 32'h0);
    chk("b_data0", wd[base], 32'h11223344);
    chk("b_data1", wd[base+1], 32'h55667788);

    // length 0, then MAX_WORDS+1, then MAX_WORDS accepted
    pulse_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    chk("len0_err", boot_err, 1);
    send(8'hA5); send(8'h05);
    chk("len5_err_clr", boot_err, 0);
    send(8'h00);
    idle(1);
    chk("len5_err", boot_err, 1);
    send(8'hA5); send(8'h04); send(8'h00);
    idle(1);
    chk("len4_ok", boot_err, 0);
    chk("len_nwr", wr_cnt - base, 0);

    // timeout after a partial word
    pulse_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03);
    idle(16);
    chk("to_15_err", boot_err, 0);
    idle(1);
    chk("to_16_err", boot_err, 1);
    chk("to_core", core_rst_n, 0);
    chk("to_nwr", wr_cnt - base, 0);

    // byte lands exactly on the 16th idle cycle
    pulse_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03);
    idle(15);
    send(8'h04);
    send(8'h04);
    chk("to_edge_err", boot_err, 0);
    idle(1);
    chk("to_edge_done", boot_done, 1);
    chk("to_edge_nwr", wr_cnt - base, 1);
    chk("to_edge_data", wd[base], 32'h04030201);

    // reset after 6 of 8 data bytes
    pulse_reset();
    base = wr_cnt;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h08); send(8'h20);
    send(8'hFF); send(8'hFF);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_wr_en", imem_wr_en, 0);
    chk("mid_rst_addr", imem_wr_addr, 0);
    chk("mid_rst_data", imem_wr_data, 0);
    chk("mid_rst_core", core_rst_n, 0);
    chk("mid_rst_err", boot_err, 0);
    rst_n = 1'b1;
    send(8'h08); send(8'h10);
    idle(2);
    chk("mid_rst_nwr", wr_cnt - base, 1);
    chk("mid_rst_done", boot_done, 0);
    base = wr_cnt;
    frame_a(8'h23);
    idle(1);
    chk("reload_done", boot_done, 1);
    chk("reload_nwr", wr_cnt - base, 2);
    chk("reload_data1", wd[base+1], 32'h1008FFFF);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
